// File: rtl/tc_pkg.sv
// Shared definitions for the two-phase storage components: state commits on
// the falling edge, visible outputs register on the rising edge.
package tc_pkg;

    localparam logic TC_STATE_ON_NEGEDGE = 1'b1;
    localparam logic TC_OUTPUT_ON_POSEDGE = 1'b1;

    // Operation requested at a negedge, encoded as {save, load}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } tc_op_e;

    function automatic int tc_clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tc_stack_mem.sv
// Stack storage array: one shared address, negedge read and write ports,
// read-before-write when both hit the same entry.
module tc_stack_mem
    import tc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 256,
    localparam int ADDR_W   = tc_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [BIT_WIDTH-1:0] i_wdata,
    output logic [BIT_WIDTH-1:0] o_rdata
);

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [BIT_WIDTH-1:0] r_rdata;

    // Non-blocking read and write on the same edge give the old word on a swap.
    always_ff @(negedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tc_stack.sv
// LIFO stack with a saturating pointer; pointer and storage commit on negedge,
// popped word and status flags register on posedge.
module tc_stack
    import tc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 save,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PTR_W  = tc_clog2(DEPTH) + 1;
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] SP_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] SP_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] SP_FULL = {1'b1, {(PTR_W-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] WORD_ZERO = {BIT_WIDTH{1'b0}};

    logic                 r_rst_q;
    logic [PTR_W-1:0]     r_sp;
    logic                 r_rd_valid;
    logic                 r_rd_hit;
    logic                 r_ovf;
    logic                 r_unf;
    logic [BIT_WIDTH-1:0] r_out;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_overflow;
    logic                 r_underflow;

    tc_op_e               w_op;
    logic                 w_sp_zero;
    logic                 w_sp_full;
    logic [PTR_W-1:0]     w_sp_dec;
    logic [PTR_W-1:0]     w_sp_nxt;
    logic                 w_we;
    logic                 w_re;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_rd_hit;
    logic                 w_set_ovf;
    logic                 w_set_unf;
    logic [BIT_WIDTH-1:0] w_mem_rdata;
    logic [BIT_WIDTH-1:0] w_rd_q;

    assign w_op      = tc_op_e'({save, load});
    assign w_sp_zero = (r_sp == SP_ZERO);
    assign w_sp_full = (r_sp == SP_FULL);
    assign w_sp_dec  = r_sp - SP_ONE;

    // Decode the pending operation into memory strobes and the next pointer.
    always_comb begin
        w_we      = 1'b0;
        w_re      = 1'b0;
        w_addr    = r_sp[ADDR_W-1:0];
        w_sp_nxt  = r_sp;
        w_rd_hit  = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (r_rst_q) begin
            w_sp_nxt = SP_ZERO;
        end else begin
            case (w_op)
                OP_POP: begin
                    if (w_sp_zero) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_re     = 1'b1;
                        w_rd_hit = 1'b1;
                        w_addr   = w_sp_dec[ADDR_W-1:0];
                        w_sp_nxt = w_sp_dec;
                    end
                end
                OP_PUSH: begin
                    if (w_sp_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_sp_nxt = r_sp + SP_ONE;
                    end
                end
                OP_SWAP: begin
                    w_we = 1'b1;
                    if (w_sp_zero) begin
                        // Nothing to return, but the word still lands in entry 0.
                        w_set_unf = 1'b1;
                        w_sp_nxt  = SP_ONE;
                    end else begin
                        w_re     = 1'b1;
                        w_rd_hit = 1'b1;
                        w_addr   = w_sp_dec[ADDR_W-1:0];
                    end
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end
    end

    tc_stack_mem #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (in),
        .o_rdata (w_mem_rdata)
    );

    // Negedge state: pointer, read qualifiers and sticky error flags.
    always_ff @(negedge clk) begin
        if (r_rst_q) begin
            r_sp       <= SP_ZERO;
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_sp       <= w_sp_nxt;
            r_rd_valid <= load;
            r_rd_hit   <= w_rd_hit;
            r_ovf      <= r_ovf | w_set_ovf;
            r_unf      <= r_unf | w_set_unf;
        end
    end

    assign w_rd_q = r_rd_hit ? w_mem_rdata : WORD_ZERO;

    // Posedge outputs; reset is also captured here for the following negedge.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_out       <= WORD_ZERO;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out       <= r_rd_valid ? w_rd_q : WORD_ZERO;
            r_empty     <= w_sp_zero;
            r_full      <= w_sp_full;
            r_overflow  <= r_ovf;
            r_underflow <= r_unf;
        end
    end

    assign out       = r_out;
    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_tc_stack.sv
// Bench for tc_stack: queue-based stack model checked every posedge, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_tc_stack;

    localparam int BW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          save;
    logic          load;
    logic [BW-1:0] in;
    logic [BW-1:0] out;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int total;
    int bad;

    logic [BW-1:0] stk[$];
    logic [BW-1:0] m_pend;
    logic          m_ovf;
    logic          m_unf;

    logic          exp_valid;
    logic [BW-1:0] e_out;
    logic          e_empty;
    logic          e_full;
    logic          e_ovf;
    logic          e_unf;

    tc_stack #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .save      (save),
        .load      (load),
        .in        (in),
        .out       (out),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after a negedge. They are sampled by the next
    // posedge (rst) and the negedge after it (save/load). The model computes
    // what that posedge must show, then applies the operation.
    task automatic step(input logic r, input logic s, input logic l, input logic [BW-1:0] d);
        @(negedge clk);
        #1;
        rst = r; save = s; load = l; in = d;
        if (r) begin
            e_out = '0; e_empty = 1'b1; e_full = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        end else begin
            e_out   = m_pend;
            e_empty = (stk.size() == 0);
            e_full  = (stk.size() == DEPTH);
            e_ovf   = m_ovf;
            e_unf   = m_unf;
        end
        exp_valid = 1'b1;
        if (r) begin
            stk.delete();
            m_pend = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (l) begin
            if (stk.size() == 0) begin
                m_pend = '0;
                m_unf  = 1'b1;
                if (s) stk.push_back(d);
            end else begin
                m_pend = stk[$];
                if (s) stk[$] = d;
                else void'(stk.pop_back());
            end
        end else begin
            m_pend = '0;
            if (s) begin
                if (stk.size() < DEPTH) stk.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    // Model comparison on every posedge once stimulus has started.
    always @(posedge clk) begin
        #1;
        if (exp_valid) begin
            chk("out", 32'(out), 32'(e_out));
            chk("empty", 32'(empty), 32'(e_empty));
            chk("full", 32'(full), 32'(e_full));
            chk("overflow", 32'(overflow), 32'(e_ovf));
            chk("underflow", 32'(underflow), 32'(e_unf));
        end
    end

    initial begin
        total = 0; bad = 0;
        exp_valid = 1'b0;
        rst = 1'b1; save = 1'b0; load = 1'b0; in = '0;
        m_pend = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // LIFO order
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t1_pop33", 32'(out), 32'h33);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t1_pop22", 32'(out), 32'h22);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t1_pop11", 32'(out), 32'h11);
        chk("t1_empty", 32'(empty), 32'h1);

        // Underflow on empty
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t2_out", 32'(out), 32'h0);
        chk("t2_unf", 32'(underflow), 32'h1);
        chk("t2_empty", 32'(empty), 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t2_unf_sticky", 32'(underflow), 32'h1);

        // Full and overflow
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t3_full", 32'(full), 32'h1);
        chk("t3_ovf", 32'(overflow), 32'h1);
        for (int i = 4; i >= 1; i--) begin
            step(1'b0, 1'b0, (i > 1) ? 1'b1 : 1'b0, 8'h00);
            at_pos(); chk("t3_pop", 32'(out), 32'(i));
        end

        // Swap on a non-empty and on an empty stack
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hA0);
        step(1'b0, 1'b1, 1'b1, 8'hB0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t4_swap_old", 32'(out), 32'hA0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t4_swap_new", 32'(out), 32'hB0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t4_empty_swap_out", 32'(out), 32'h0);
        chk("t4_empty_swap_unf", 32'(underflow), 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t4_pop77", 32'(out), 32'h77);

        // Reset wins over a pending pop
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        at_pos(); chk("t5_rst_out", 32'(out), 32'h0);
        chk("t5_rst_empty", 32'(empty), 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t5_no_pop", 32'(out), 32'h0);
        chk("t5_flags", 32'({overflow, underflow}), 32'h0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t5_unf", 32'(underflow), 32'h1);

        // Push then pop back-to-back
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hC3);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t6_out", 32'(out), 32'hC3);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos(); chk("t6_out_cleared", 32'(out), 32'h0);

        // Randomized traffic, occasional reset
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        at_pos();
        exp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
